// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared state encoding and defaults for the UART TX arbiter slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEFAULT_DWIDTH = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module : rr_priority_pick
// Brief  : Combinational round-robin pick: first set req bit after 'last'.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  winner,
    output logic            valid
);

    logic [IDW-1:0] w_idx;

    assign valid = |req;

    // Scan from the farthest candidate down to last+1 so the nearest set bit wins.
    always_comb begin
        winner = '0;
        w_idx  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_idx = IDW'((int'(last) + i) % NREQ);
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin sharing of one uart_tx serializer among NREQ producers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DWIDTH       = DEFAULT_DWIDTH,
    parameter int NREQ         = 4,
    parameter int IDW          = 2,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    input  logic                   busy_tx,
    output logic [DWIDTH-1:0]      p_data_tx,
    output logic                   data_valid_tx,
    output logic [IDW-1:0]         grant_id,
    output logic                   active,
    output logic                   timeout_err
);

    arb_state_t      r_state;
    arb_state_t      w_state_next;
    logic [IDW-1:0]  r_last;
    logic [7:0]      r_timer;
    logic [IDW-1:0]  w_winner;
    logic            w_valid;
    logic [NREQ-1:0] w_ack_onehot;

    rr_priority_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req),
        .last   (r_last),
        .winner (w_winner),
        .valid  (w_valid)
    );

    assign w_ack_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
    assign data_valid_tx = (r_state == LAUNCH);

    // IDLE holds off during the ack cycle so the acked requester can drop req.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if ((|req) && !busy_tx && (ack == '0)) w_state_next = GRANT;
            GRANT:     w_state_next = w_valid ? LAUNCH : IDLE;
            LAUNCH:    w_state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy_tx)                                  w_state_next = WAIT_DONE;
                else if (r_timer == 8'(BUSY_TIMEOUT - 1))     w_state_next = IDLE;
            end
            WAIT_DONE: if (!busy_tx) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= IDW'(NREQ - 1);
            r_timer     <= '0;
            ack         <= '0;
            p_data_tx   <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            ack     <= '0;
            case (r_state)
                IDLE: begin
                    if (ack != '0) active <= 1'b0;
                end
                GRANT: begin
                    if (w_valid) begin
                        p_data_tx <= req_data[w_winner*DWIDTH +: DWIDTH];
                        grant_id  <= w_winner;
                        r_last    <= w_winner;
                        active    <= 1'b1;
                    end
                end
                LAUNCH: r_timer <= '0;
                WAIT_BUSY: begin
                    if (!busy_tx) begin
                        if (r_timer == 8'(BUSY_TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                            ack         <= w_ack_onehot;
                            active      <= 1'b0;
                        end else begin
                            r_timer <= r_timer + 8'd1;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!busy_tx) ack <= w_ack_onehot;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Directed, table-driven bench for uart_tx_arbiter with a busy model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        busy_tx;
    logic [7:0]  p_data_tx;
    logic        data_valid_tx;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    logic model_en   = 1'b1;
    logic model_busy = 1'b0;
    int   model_cnt  = 0;
    int   busy_len   = 10;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [1:0]  exp_id;
        int          blen;
    } vec_t;

    vec_t vecs [9];

    uart_tx_arbiter #(
        .DWIDTH       (8),
        .NREQ         (4),
        .IDW          (2),
        .BUSY_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .busy_tx       (busy_tx),
        .p_data_tx     (p_data_tx),
        .data_valid_tx (data_valid_tx),
        .grant_id      (grant_id),
        .active        (active),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy for busy_len cycles after each launch; unaffected by rst.
    always @(posedge clk) begin
        if (model_en && data_valid_tx) begin
            model_busy <= 1'b1;
            model_cnt  <= busy_len;
        end else if (model_cnt > 1) begin
            model_cnt <= model_cnt - 1;
        end else if (model_cnt == 1) begin
            model_cnt  <= 0;
            model_busy <= 1'b0;
        end
    end
    assign busy_tx = model_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dv(output int n);
        n = 0;
        while (!data_valid_tx && n < 80) begin
            tick();
            n++;
        end
        check("dv_seen", 64'(data_valid_tx), 64'd1);
    endtask

    task automatic run_frame(input logic [3:0] r, input logic [31:0] data,
                             input logic [1:0] exp_id, input int blen, input bit chk_lat);
        int n;
        logic [3:0] onehot;
        onehot   = 4'b0001 << exp_id;
        req_data = data;
        busy_len = blen;
        req      = r;
        wait_dv(n);
        if (chk_lat) check("launch_latency", 64'(n), 64'd2);
        check("grant_id", 64'(grant_id), 64'(exp_id));
        check("p_data_tx", 64'(p_data_tx), 64'(data[exp_id*8 +: 8]));
        n = 0;
        while (!busy_tx && n < 5) begin tick(); n++; end
        n = 0;
        while (busy_tx && n < blen + 10) begin tick(); n++; end
        check("busy_fell", 64'(busy_tx), 64'd0);
        tick();
        check("ack_onehot", 64'(ack), 64'(onehot));
        check("active_at_ack", 64'(active), 64'd1);
        req = '0;
        tick();
        check("ack_one_cycle", 64'({ack, active}), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int viol;

        vecs[0] = '{4'b0100, 32'h44A52211, 2'd2, 100};
        vecs[1] = '{4'b1001, 32'h44332211, 2'd3, 6};
        vecs[2] = '{4'b1001, 32'h44332211, 2'd0, 6};
        vecs[3] = '{4'b1001, 32'h44332211, 2'd3, 6};
        vecs[4] = '{4'b1111, 32'h44332211, 2'd0, 6};
        vecs[5] = '{4'b1111, 32'h44332211, 2'd1, 6};
        vecs[6] = '{4'b1111, 32'h44332211, 2'd2, 6};
        vecs[7] = '{4'b1111, 32'h44332211, 2'd3, 6};
        vecs[8] = '{4'b1111, 32'h44332211, 2'd0, 6};

        repeat (3) tick();
        check("reset_outputs", 64'({ack, p_data_tx, data_valid_tx, grant_id, active, timeout_err}), 64'd0);
        rst = 1'b0;
        tick();

        // Single request, then round-robin wrap with req=1001.
        for (int i = 0; i < 4; i++)
            run_frame(vecs[i].req, vecs[i].data, vecs[i].exp_id, vecs[i].blen, 1'b1);

        // Reset while WAIT_DONE: outputs clear, uart still busy, then req[0] wins.
        req_data = 32'h44332211;
        busy_len = 30;
        req      = 4'b0010;
        wait_dv(n);
        check("pre_rst_grant", 64'(grant_id), 64'd1);
        n = 0;
        while (!busy_tx && n < 5) begin tick(); n++; end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_in_wait_done", 64'({ack, p_data_tx, data_valid_tx, grant_id, active, timeout_err}), 64'd0);
        rst  = 1'b0;
        req  = 4'b0101;
        viol = 0;
        n    = 0;
        check("stale_busy_high", 64'(busy_tx), 64'd1);
        while (busy_tx && n < 60) begin
            if (ack != '0 || active || data_valid_tx) viol++;
            tick();
            n++;
        end
        check("idle_while_busy", 64'(viol), 64'd0);
        run_frame(4'b0101, 32'h44332211, 2'd0, 8, 1'b0);

        // Busy never rises: sticky timeout after 15 WAIT_BUSY cycles.
        model_en = 1'b0;
        req_data = 32'h44C32211;
        req      = 4'b0100;
        wait_dv(n);
        check("to_grant", 64'(grant_id), 64'd2);
        viol = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (ack != '0 || timeout_err || !active) viol++;
        end
        check("to_not_early", 64'(viol), 64'd0);
        tick();
        check("to_ack", 64'({ack, timeout_err, active}), 64'({4'b0100, 1'b1, 1'b0}));
        req = '0;
        tick();
        check("to_sticky", 64'({ack, timeout_err}), 64'({4'b0000, 1'b1}));
        model_en = 1'b1;
        run_frame(4'b0001, 32'h44332211, 2'd0, 8, 1'b1);
        check("to_still_sticky", 64'(timeout_err), 64'd1);

        // Requester drops req and changes data mid-frame.
        req_data = 32'h5A332211;
        busy_len = 12;
        req      = 4'b1000;
        wait_dv(n);
        check("drop_grant", 64'({grant_id, p_data_tx}), 64'({2'd3, 8'h5A}));
        n = 0;
        while (!busy_tx && n < 5) begin tick(); n++; end
        tick();
        req      = '0;
        req_data = 32'hFFFFFFFF;
        n = 0;
        while (busy_tx && n < 30) begin tick(); n++; end
        tick();
        check("drop_ack", 64'({ack, p_data_tx}), 64'({4'b1000, 8'h5A}));
        viol = 0;
        repeat (8) begin
            tick();
            if (data_valid_tx || ack != '0) viol++;
        end
        check("drop_no_regrant", 64'(viol), 64'd0);
        check("drop_inactive", 64'(active), 64'd0);

        // All four requesting: order 0,1,2,3,0.
        for (int i = 4; i < 9; i++)
            run_frame(vecs[i].req, vecs[i].data, vecs[i].exp_id, vecs[i].blen, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one uart_tx serializer between NREQ byte producers.
- Grants one requester and latches its byte, then pulses data_valid to uart_tx. It tracks the busy handshake until the frame completes, then pulses ack to the winner.
- Sits between the requesters and the uart_tx p_data / data_valid / busy interface. Runs on the TX clock domain.

Parameters:
- DWIDTH, 8, data byte width; must match uart_tx DWIDTH.
- NREQ, 4, number of requesters; 2..16.
- IDW, 2, width of grant_id; equals clog2(NREQ), minimum 1.
- BUSY_TIMEOUT, 15, cycles to wait for busy to rise after launch before flagging an error; 1..255.

Ports:
- clk  in  1  TX clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; held high until ack.
- req_data  in  NREQ*DWIDTH  byte for requester i, in bits [i*DWIDTH +: DWIDTH]; sampled only at grant.
- ack  out  NREQ  one-hot one-cycle pulse: byte of requester i fully transmitted, or aborted on timeout.
- busy_tx  in  1  busy from uart_tx.
- p_data_tx  out  DWIDTH  byte to uart_tx.
- data_valid_tx  out  1  one-cycle launch strobe to uart_tx.
- grant_id  out  IDW  index of the current or last winner.
- active  out  1  high from grant until ack, inclusive.
- timeout_err  out  1  sticky; set when busy fails to rise within BUSY_TIMEOUT cycles; cleared only by rst.

Behaviour:
- Reset values: ack=0, p_data_tx=0, data_valid_tx=0, grant_id=0, active=0, timeout_err=0, state=IDLE, last=NREQ-1 (so req[0] has top priority first), timer=0.
- Reset asserted in any state forces all reset values at the next edge. Any frame in flight in uart_tx is not tracked; no ack is issued for it.
- State IDLE: if any req bit is set and busy_tx=0, go to GRANT. If busy_tx=1 (foreign or stale frame), wait.
- State GRANT (1 cycle):
  - Winner = first set bit of req, searching from last+1 upward with wrap-around.
  - Latch req_data slice into p_data_tx; set grant_id=winner, last=winner, active=1; go to LAUNCH.
  - Arbitration uses req as sampled in IDLE's exit cycle registered into GRANT. If all req bits dropped by GRANT, return to IDLE with active=0 and no ack.
- State LAUNCH (1 cycle): data_valid_tx=1; timer cleared; go to WAIT_BUSY.
- State WAIT_BUSY:
  - busy_tx=1: go to WAIT_DONE.
  - Otherwise timer increments. On timer==BUSY_TIMEOUT: set timeout_err, pulse ack[winner], drop active, go to IDLE.
- State WAIT_DONE: on busy_tx=0, pulse ack[winner] for one cycle with active still 1, then go to IDLE (active=0 next cycle).
- Latency:
  - From req rising in IDLE (busy_tx=0) to data_valid_tx: 2 cycles (IDLE edge to GRANT, GRANT edge to LAUNCH).
  - From busy_tx falling to ack: 1 cycle.
- Minimum gap between back-to-back grants: ack cycle plus IDLE, then GRANT.
- Fairness: a requester granted is lowest priority next arbitration. With all NREQ requesting continuously, each is served once per NREQ frames.
- Requester dropping req after grant does not abort; ack is still issued.
- req_data changes after grant have no effect.
- p_data_tx holds the latched byte until the next GRANT.

Decomposition:
- Shared package uart_pkg: state encoding constants (IDLE, GRANT, LAUNCH, WAIT_BUSY, WAIT_DONE), default DWIDTH.
- One sub-module: rr_priority_pick. It is combinational and finds the first set bit of req rotated from last+1, producing winner index and valid. It is reusable by a future RX dispatch block.

Test Plan:
- Single req: req=4'b0100, byte 0xA5; model uart_tx busy for 100 cycles -> data_valid_tx 2 cycles after req, p_data_tx=0xA5, grant_id=2, ack=4'b0100 one cycle after busy falls.
- All four requesting with bytes 0x11/0x22/0x33/0x44, held -> launch order 0,1,2,3,0; each ack one-hot in matching order.
- Round-robin wrap: last=3; req=4'b1001 -> grant 0. Next with req=4'b1001 -> grant 3.
- Busy never rises; BUSY_TIMEOUT=15 -> after 15 WAIT_BUSY cycles, timeout_err=1 (sticky), ack pulsed, state IDLE. A subsequent normal frame still completes.
- rst asserted in WAIT_DONE -> next cycle all outputs at reset values, no ack. With busy_tx=1, it stays IDLE until busy_tx=0, then grants req[0] first.
- req pulled low during WAIT_DONE and req_data changed -> byte transmitted unchanged, ack still issued, no regrant.
